// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer
//   Captures one N-point complex FFT frame on a single-cycle strobe and feeds
//   it, one byte at a time, into an SPI master's TX byte handshake. Samples are
//   sign-extended to 8 or 16 bits and sent MSB byte first, as re[k] then im[k]
//   for k = 0..N_POINTS-1. A frame that arrives while one is still being sent
//   is dropped, and the sticky overrun flag is set.
//
//   Optional feature macro: FFT_FRAME_HEADER_EN
//     When defined, each frame starts with SYNC_BYTE and an 8-bit frame
//     sequence number (0 after reset, +1 per completed frame, wraps at 255).
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   i_fft_valid      1-cycle strobe: i_fft_re / i_fft_im hold a full frame
//   i_fft_re/_im     N_POINTS*DATA_W packed samples, point k at [k*DATA_W +: DATA_W]
//   i_tx_ready       SPI master ready
//   o_tx_byte        byte to send, held from o_tx_dv until the next o_tx_dv
//   o_tx_dv          1-cycle byte-valid strobe
//   o_busy           high from capture until the last byte is accepted
//   o_frame_done     1-cycle pulse when the last byte is accepted
//   i_clr_overrun    synchronous clear of o_overrun
//   o_overrun        sticky: a frame arrived while busy and was dropped
module fft_frame_streamer #(
  parameter int unsigned N_POINTS   = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 100,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_fft_valid,
  input  logic [N_POINTS*DATA_W-1:0]   i_fft_re,
  input  logic [N_POINTS*DATA_W-1:0]   i_fft_im,
  input  logic                         i_tx_ready,
  output logic [7:0]                   o_tx_byte,
  output logic                         o_tx_dv,
  output logic                         o_busy,
  output logic                         o_frame_done,
  input  logic                         i_clr_overrun,
  output logic                         o_overrun
);

  localparam int unsigned BPS     = (DATA_W <= 8) ? 1 : 2;
  localparam int unsigned SW      = 8 * BPS;
  localparam int unsigned PAYLOAD = N_POINTS * 2 * BPS;
`ifdef FFT_FRAME_HEADER_EN
  localparam int unsigned HDR     = 2;
`else
  localparam int unsigned HDR     = 0;
`endif
  localparam int unsigned TOTAL    = HDR + PAYLOAD;
  localparam int unsigned IDX_W    = $clog2(TOTAL) + 1;
  localparam int unsigned PT_W     = $clog2(N_POINTS);
  localparam int unsigned P_W      = PT_W + BPS;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT_RDY,
    S_GAP
  } state_t;

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [GAP_W-1:0]             r_gap;
  logic [N_POINTS*DATA_W-1:0]   r_buf_re;
  logic [N_POINTS*DATA_W-1:0]   r_buf_im;
  logic [7:0]                   r_tx_byte;
  logic                         r_tx_dv;
  logic                         r_busy;
  logic                         r_frame_done;
  logic                         r_overrun;
`ifdef FFT_FRAME_HEADER_EN
  logic [7:0]                   r_seq;
`endif

  logic                         w_capture;
  logic [IDX_W-1:0]             w_sel;
  logic [P_W-1:0]               w_p;
  logic [PT_W-1:0]              w_pt;
  logic                         w_is_im;
  logic signed [DATA_W-1:0]     w_samp;
  logic [SW-1:0]                w_ext;
  logic [7:0]                   w_pay;
  logic [7:0]                   w_byte;

  // The frame_done cycle still belongs to the finishing frame: a strobe there
  // is dropped as an overrun even though the FSM has already reached IDLE.
  assign w_capture = i_fft_valid && (r_state == S_IDLE) && !r_frame_done;

  // Byte selection. In WAIT_RDY the next byte is looked up so that a zero-gap
  // build can issue it straight from WAIT_RDY.
  always_comb begin
    w_sel   = (r_state == S_WAIT_RDY) ? (r_idx + IDX_W'(1)) : r_idx;
    w_p     = P_W'(w_sel - IDX_W'(HDR));
    w_pt    = w_p[BPS +: PT_W];
    w_is_im = w_p[BPS-1];
    w_samp  = w_is_im ? r_buf_im[w_pt*DATA_W +: DATA_W]
                      : r_buf_re[w_pt*DATA_W +: DATA_W];
    w_ext   = SW'(w_samp);
    w_pay   = (BPS == 2 && !w_p[0]) ? w_ext[SW-1 -: 8] : w_ext[7:0];
`ifdef FFT_FRAME_HEADER_EN
    if (w_sel == '0)
      w_byte = SYNC_BYTE;
    else if (w_sel == IDX_W'(1))
      w_byte = r_seq;
    else
      w_byte = w_pay;
`else
    w_byte  = w_pay;
`endif
  end

  // Frame buffer has no reset; it is only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf_re <= i_fft_re;
      r_buf_im <= i_fft_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_gap        <= '0;
      r_tx_byte    <= '0;
      r_tx_dv      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef FFT_FRAME_HEADER_EN
      r_seq        <= '0;
`endif
    end else begin
      r_tx_dv      <= 1'b0;
      r_frame_done <= 1'b0;

      // Set has priority over clear.
      if (i_clr_overrun)
        r_overrun <= 1'b0;
      if (i_fft_valid && !w_capture)
        r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_tx_ready) begin
            r_tx_byte <= w_byte;
            r_tx_dv   <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_state <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (i_tx_ready) begin
            if (r_idx == LAST_IDX) begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
`ifdef FFT_FRAME_HEADER_EN
              r_seq        <= r_seq + 8'd1;
`endif
              r_state      <= S_IDLE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              if (GAP_CYCLES == 0) begin
                // Ready is already high, so issuing here saves the ISSUE
                // cycle and gives DV one cycle after ready rises.
                r_tx_byte <= w_byte;
                r_tx_dv   <= 1'b1;
                r_state   <= S_HOLD;
              end else begin
                r_gap   <= GAP_W'(GAP_LOAD);
                r_state <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0)
            r_state <= S_ISSUE;
          else
            r_gap <= r_gap - GAP_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_byte    = r_tx_byte;
  assign o_tx_dv      = r_tx_dv;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule
